// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int len_w(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Masked compare of the bit window against the low 'len' pattern bits.
// Purely combinational; no flow control.
module seq_window_cmp
    import seq_det_pkg::*;
#(
    parameter  int PAT_MAX = 8,
    localparam int LEN_W   = len_w(PAT_MAX)
) (
    input  logic [PAT_MAX-1:0] window,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < PAT_MAX; i++) begin
            if ((i < int'(len)) && (window[i] != pattern[i])) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: Mealy hit, registered hit, saturating count.
// detected is same-cycle, detected_q one cycle later; input is qualified by din_valid only.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int PAT_MAX = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = len_w(PAT_MAX)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               detected,
    output logic               detected_q,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    state_t               state_q;
    state_t               state_d;
    logic [PAT_MAX-2:0]   hist;
    logic [LEN_W-1:0]     fill;
    logic [PAT_MAX-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 overlap_q;

    logic [PAT_MAX-1:0]   window;
    logic                 win_match;
    logic                 cfg_legal;
    logic [LEN_W:0]       fill_p1;
    logic                 fill_ok;
    logic [LEN_W-1:0]     fill_inc;
    logic                 hit;

    assign window    = {hist, din};
    assign cfg_legal = (pat_len != '0) && (int'(pat_len) <= PAT_MAX);
    // fill >= len-1 written as fill+1 >= len so len=1 cannot underflow
    assign fill_p1   = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_ok   = fill_p1 >= {1'b0, len_q};
    assign fill_inc  = (int'(fill) == PAT_MAX) ? fill : fill + 1'b1;

    seq_window_cmp #(
        .PAT_MAX (PAT_MAX)
    ) u_cmp (
        .window  (window),
        .pattern (pat_q),
        .len     (len_q),
        .match   (win_match)
    );

    // A config load takes priority over the data bit presented in the same cycle.
    assign hit      = (state_q == RUN) && din_valid && !cfg_load && fill_ok && win_match;
    assign detected = hit;

    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = cfg_legal ? RUN : UNCFG;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= UNCFG;
            armed   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed   <= (state_d == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist      <= '0;
            fill      <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (cfg_load) begin
            hist    <= '0;
            fill    <= '0;
            cfg_err <= !cfg_legal;
            if (cfg_legal) begin
                pat_q     <= pattern;
                len_q     <= pat_len;
                overlap_q <= overlap_en;
            end
        end else if (din_valid && (state_q == RUN)) begin
            hist <= window[PAT_MAX-2:0];
            fill <= (hit && !overlap_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            detected_q  <= 1'b0;
            match_count <= '0;
        end else begin
            detected_q <= hit;
            if (cnt_clr) begin
                match_count <= '0;
            end else if (hit && !(&match_count)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: the driver queues the tag of each bit expected to hit, the monitor pops on detected.
module tb_seq_detector_prog;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_load = 1'b0;
    logic [PAT_MAX-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap_en = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               detected;
    logic               detected_q;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    int n_cmp = 0;
    int n_fail = 0;
    int cur_tag = 0;
    int exp_q[$];

    seq_detector_prog #(
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .din_valid   (din_valid),
        .din         (din),
        .cnt_clr     (cnt_clr),
        .detected    (detected),
        .detected_q  (detected_q),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic b, input bit exp_hit);
        din_valid = v;
        din       = b;
        cur_tag++;
        if (exp_hit) exp_q.push_back(cur_tag);
        step();
        din_valid = 1'b0;
        din       = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input logic [7:0] hits);
        for (int i = n - 1; i >= 0; i--) begin
            send(1'b1, bits[i], hits[i]);
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic dv, input logic d);
        pattern    = pat;
        pat_len    = len;
        overlap_en = ov;
        cfg_load   = 1'b1;
        din_valid  = dv;
        din        = d;
        cur_tag++;
        step();
        cfg_load  = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        step();
        check({name, "_pending_hits"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: checks every Mealy hit against the queue and detected_q against the previous cycle.
    initial begin
        int pd;
        int pr;
        int t;
        pd = 0;
        pr = 0;
        forever begin
            @(negedge clk);
            check("detected_q", int'(detected_q), (pr != 0) ? pd : 0);
            if (detected) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hit_tag", cur_tag, -1);
                end else begin
                    t = exp_q.pop_front();
                    check("hit_tag", cur_tag, t);
                end
            end
            pd = int'(detected);
            pr = int'(reset_n);
        end
    end

    initial begin
        // Reset, with data toggling to show no hit while unconfigured
        reset_n   = 1'b0;
        din_valid = 1'b1;
        din       = 1'b1;
        step();
        step();
        din_valid = 1'b0;
        check("rst_armed", int'(armed), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_detected_q", int'(detected_q), 0);
        reset_n = 1'b1;
        step();

        // 1) overlapping 1011: hits on bits 4 and 7
        cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        check("t1_armed", int'(armed), 1);
        check("t1_cfg_err", int'(cfg_err), 0);
        send_bits(8'b0101_1011, 7, 8'b0000_1001);
        check("t1_count", int'(match_count), 2);
        drain("t1");
        clr();

        // 2) non-overlapping: only bit 4 hits
        cfg(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
        send_bits(8'b0101_1011, 7, 8'b0000_1000);
        check("t2_count", int'(match_count), 1);
        drain("t2");

        // 3) illegal lengths and recovery
        cfg(8'b0000_0101, 4'd0, 1'b1, 1'b0, 1'b0);
        check("t3_len0_cfg_err", int'(cfg_err), 1);
        check("t3_len0_armed", int'(armed), 0);
        cfg(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0);
        check("t3_len3_cfg_err", int'(cfg_err), 0);
        check("t3_len3_armed", int'(armed), 1);
        send_bits(8'b0000_0101, 3, 8'b0000_0001);
        check("t3_count", int'(match_count), 2);
        cfg(8'b0000_0101, 4'd9, 1'b1, 1'b0, 1'b0);
        check("t3_len9_cfg_err", int'(cfg_err), 1);
        check("t3_len9_armed", int'(armed), 0);
        send_bits(8'b0000_0101, 3, 8'b0000_0000);
        check("t3_uncfg_count", int'(match_count), 2);
        drain("t3");

        // 4) valid gaps inside 1011, including a gap carrying the completing bit value
        clr();
        cfg(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check("t4_count", int'(match_count), 1);
        drain("t4");

        // 5) len=1, counter saturation, cnt_clr beats a same-cycle hit
        clr();
        cfg(8'b0000_0001, 4'd1, 1'b0, 1'b0, 1'b0);
        send_bits(8'b0001_1111, 6, 8'b0001_1111);
        check("t5_sat_count", int'(match_count), 3);
        cnt_clr = 1'b1;
        send(1'b1, 1'b1, 1'b1);
        check("t5_clr_wins", int'(match_count), 0);
        drain("t5");

        // 6) reset mid-pattern, then cfg_load discards its own data bit
        cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        send_bits(8'b0000_1011, 4, 8'b0000_0001);
        check("t6_pre_count", int'(match_count), 1);
        send_bits(8'b0000_0101, 3, 8'b0000_0000);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("t6_rst_armed", int'(armed), 0);
        check("t6_rst_cfg_err", int'(cfg_err), 0);
        check("t6_rst_count", int'(match_count), 0);
        check("t6_rst_detected_q", int'(detected_q), 0);
        send(1'b1, 1'b1, 1'b0);
        cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
        send_bits(8'b0000_0011, 3, 8'b0000_0000);
        check("t6_discard_count", int'(match_count), 0);
        send_bits(8'b0000_0011, 3, 8'b0000_0001);
        check("t6_final_count", int'(match_count), 1);
        drain("t6");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
